sparse_systolic_array: RTL

Parametrised successor to the fixed 4x4 sparse PE array. It is an output-stationary ROWS x COLS systolic array computing C[r][c] = Psum[r][c] + sum over k of A[r][k]*W[k][c]. Per-row activation masks skip zero multiplies. A control FSM sequences optional partial-sum preload, K-beat compute, skew flush and row-wise result drain. It sits between the activation/weight buffers and the output/partial-sum buffer, and replaces the hard-wired Block_control/Direction/Control/ResultCapture pins with handshakes.

---
 rtl/sparse_array_pkg.sv | 42 ++++
 rtl/sparse_pe.sv | 61 ++++++
 rtl/sparse_systolic_array.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_array_pkg.sv
// rtl/sparse_array_pkg.sv - shared state encoding and saturating arithmetic for the sparse array
package sparse_array_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    COMPUTE,
    FLUSH,
    DRAIN
  } state_t;

  // Widest accumulator the helpers support; callers size-cast in and out.
  localparam int ACC_MAXW = 64;

  function automatic logic signed [ACC_MAXW-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [ACC_MAXW-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [ACC_MAXW-1:0] sat_add(
    input logic signed [ACC_MAXW-1:0] a,
    input logic signed [ACC_MAXW-1:0] b,
    input int                         w
  );
    logic signed [ACC_MAXW:0] s;
    logic signed [ACC_MAXW-1:0] hi;
    logic signed [ACC_MAXW-1:0] lo;
    hi = sat_max(w);
    lo = sat_min(w);
    s  = $signed({a[ACC_MAXW-1], a}) + $signed({b[ACC_MAXW-1], b});
    if (s > $signed({hi[ACC_MAXW-1], hi})) begin
      return hi;
    end else if (s < $signed({lo[ACC_MAXW-1], lo})) begin
      return lo;
    end
    return s[ACC_MAXW-1:0];
  endfunction

endpackage

// File: rtl/sparse_pe.sv
// rtl/sparse_pe.sv - one output-stationary PE with skew forwarding and saturating MAC
module sparse_pe
  import sparse_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         load,
  input  logic signed [ACC_WIDTH-1:0]  load_val,
  input  logic signed [DATA_WIDTH-1:0] act_in,
  input  logic                         mask_in,
  input  logic                         act_vld_in,
  input  logic signed [DATA_WIDTH-1:0] wt_in,
  input  logic                         wt_vld_in,
  output logic signed [DATA_WIDTH-1:0] act_out,
  output logic                         mask_out,
  output logic                         act_vld_out,
  output logic signed [DATA_WIDTH-1:0] wt_out,
  output logic                         wt_vld_out,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic                           mac_en;
  logic signed [DATA_WIDTH-1:0]   act_g;
  logic signed [DATA_WIDTH-1:0]   wt_g;
  logic signed [2*DATA_WIDTH-1:0] prod;

  // Operands are forced to zero unless the beat is real and unmasked, so the multiplier stays quiet.
  assign mac_en = act_vld_in && wt_vld_in && mask_in;
  assign act_g  = mac_en ? act_in : '0;
  assign wt_g   = mac_en ? wt_in : '0;
  assign prod   = act_g * wt_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_out     <= '0;
      mask_out    <= 1'b0;
      act_vld_out <= 1'b0;
      wt_out      <= '0;
      wt_vld_out  <= 1'b0;
      acc         <= '0;
    end else begin
      act_out     <= act_in;
      mask_out    <= mask_in;
      act_vld_out <= act_vld_in;
      wt_out      <= wt_in;
      wt_vld_out  <= wt_vld_in;
      if (clear) begin
        acc <= '0;
      end else if (load) begin
        acc <= load_val;
      end else if (mac_en) begin
        acc <= ACC_WIDTH'(sat_add(ACC_MAXW'(acc), ACC_MAXW'(prod), ACC_WIDTH));
      end
    end
  end

endmodule

// File: rtl/sparse_systolic_array.sv
// rtl/sparse_systolic_array.sv - ROWS x COLS output-stationary sparse systolic array with tile FSM
module sparse_systolic_array
  import sparse_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 64,
  parameter int KW         = $clog2(K_MAX + 1),
  parameter int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Start,
  input  logic [KW-1:0]              K_len,
  input  logic                       Preload,
  output logic                       Busy,
  output logic                       Err,
  input  logic                       Psum_valid,
  output logic                       Psum_ready,
  input  logic [COLS*ACC_WIDTH-1:0]  Psum_in,
  input  logic                       In_valid,
  output logic                       In_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] Act_in,
  input  logic [ROWS-1:0]            Act_mask,
  input  logic [COLS*DATA_WIDTH-1:0] Weight_in,
  output logic                       Out_valid,
  input  logic                       Out_ready,
  output logic [COLS*ACC_WIDTH-1:0]  Out_row,
  output logic [RW-1:0]              Out_row_idx,
  output logic                       Done
);

  localparam int             FLUSH_CYC = ROWS + COLS - 2;
  localparam int             FW        = $clog2(ROWS + COLS + 1);
  localparam logic [RW-1:0]  LAST_ROW  = RW'(ROWS - 1);

  state_t        state;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] kcnt;
  logic [RW-1:0] prow;
  logic [RW-1:0] drow;
  logic [FW-1:0] fcnt;

  logic k_ok;
  logic in_fire;
  logic psum_fire;
  logic out_fire;
  logic acc_clear;

  assign k_ok      = (K_len != '0) && (K_len <= KW'(K_MAX));
  assign in_fire   = In_valid && In_ready;
  assign psum_fire = Psum_valid && Psum_ready;
  assign out_fire  = Out_valid && Out_ready;
  assign acc_clear = (state == IDLE) && Start && k_ok && !Preload;
  assign Done      = out_fire && (drow == LAST_ROW);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      k_len_q    <= '0;
      kcnt       <= '0;
      prow       <= '0;
      drow       <= '0;
      fcnt       <= '0;
      Busy       <= 1'b0;
      Err        <= 1'b0;
      Psum_ready <= 1'b0;
      In_ready   <= 1'b0;
      Out_valid  <= 1'b0;
    end else begin
      Err <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (k_ok) begin
              k_len_q <= K_len;
              kcnt    <= '0;
              prow    <= '0;
              drow    <= '0;
              Busy    <= 1'b1;
              if (Preload) begin
                state      <= PRELOAD;
                Psum_ready <= 1'b1;
              end else begin
                state    <= COMPUTE;
                In_ready <= 1'b1;
              end
            end else begin
              Err <= 1'b1;
            end
          end
        end
        PRELOAD: begin
          if (psum_fire) begin
            if (prow == LAST_ROW) begin
              state      <= COMPUTE;
              Psum_ready <= 1'b0;
              In_ready   <= 1'b1;
            end else begin
              prow <= prow + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (in_fire) begin
            kcnt <= kcnt + 1'b1;
            if ((kcnt + KW'(1)) == k_len_q) begin
              In_ready <= 1'b0;
              if (FLUSH_CYC == 0) begin
                state     <= DRAIN;
                Out_valid <= 1'b1;
              end else begin
                state <= FLUSH;
                fcnt  <= FW'(1);
              end
            end
          end
        end
        FLUSH: begin
          // The last accepted beat lands in the far-corner PE on the final flush edge.
          if (fcnt == FW'(FLUSH_CYC)) begin
            state     <= DRAIN;
            Out_valid <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (drow == LAST_ROW) begin
              state     <= IDLE;
              Out_valid <= 1'b0;
              Busy      <= 1'b0;
              drow      <= '0;
            end else begin
              drow <= drow + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] h_act [ROWS][COLS+1];
  logic                  h_msk [ROWS][COLS+1];
  logic                  h_vld [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] v_wt  [ROWS+1][COLS];
  logic                  v_vld [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  acc_q [ROWS][COLS];

  // Row r activations are delayed r cycles before entering column 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
    if (r == 0) begin : g_direct
      assign h_act[r][0] = Act_in[r*DATA_WIDTH +: DATA_WIDTH];
      assign h_msk[r][0] = Act_mask[r];
      assign h_vld[r][0] = in_fire;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] act_d [r];
      logic                  msk_d [r];
      logic                  vld_d [r];
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          for (int i = 0; i < r; i++) begin
            act_d[i] <= '0;
            msk_d[i] <= 1'b0;
            vld_d[i] <= 1'b0;
          end
        end else begin
          act_d[0] <= Act_in[r*DATA_WIDTH +: DATA_WIDTH];
          msk_d[0] <= Act_mask[r];
          vld_d[0] <= in_fire;
          for (int i = 1; i < r; i++) begin
            act_d[i] <= act_d[i-1];
            msk_d[i] <= msk_d[i-1];
            vld_d[i] <= vld_d[i-1];
          end
        end
      end
      assign h_act[r][0] = act_d[r-1];
      assign h_msk[r][0] = msk_d[r-1];
      assign h_vld[r][0] = vld_d[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_skew
    if (c == 0) begin : g_direct
      assign v_wt[0][c]  = Weight_in[c*DATA_WIDTH +: DATA_WIDTH];
      assign v_vld[0][c] = in_fire;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] wt_d  [c];
      logic                  vld_d [c];
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          for (int i = 0; i < c; i++) begin
            wt_d[i]  <= '0;
            vld_d[i] <= 1'b0;
          end
        end else begin
          wt_d[0]  <= Weight_in[c*DATA_WIDTH +: DATA_WIDTH];
          vld_d[0] <= in_fire;
          for (int i = 1; i < c; i++) begin
            wt_d[i]  <= wt_d[i-1];
            vld_d[i] <= vld_d[i-1];
          end
        end
      end
      assign v_wt[0][c]  = wt_d[c-1];
      assign v_vld[0][c] = vld_d[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      sparse_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk        (Clk),
        .rst_n      (Rst),
        .clear      (acc_clear),
        .load       (psum_fire && (prow == RW'(r))),
        .load_val   (Psum_in[c*ACC_WIDTH +: ACC_WIDTH]),
        .act_in     (h_act[r][c]),
        .mask_in    (h_msk[r][c]),
        .act_vld_in (h_vld[r][c]),
        .wt_in      (v_wt[r][c]),
        .wt_vld_in  (v_vld[r][c]),
        .act_out    (h_act[r][c+1]),
        .mask_out   (h_msk[r][c+1]),
        .act_vld_out(h_vld[r][c+1]),
        .wt_out     (v_wt[r+1][c]),
        .wt_vld_out (v_vld[r+1][c]),
        .acc        (acc_q[r][c])
      );
    end
  end

  // Accumulators are idle during drain, so a plain mux keeps the row stable under backpressure.
  always_comb begin
    Out_row     = '0;
    Out_row_idx = '0;
    if (Out_valid) begin
      Out_row_idx = drow;
      for (int c = 0; c < COLS; c++) begin
        Out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[drow][c];
      end
    end
  end

endmodule
